// File: rtl/uart_tx_arbiter_pkg.sv
// Shared definitions for the UART TX arbiter slice.
// Contents:
//   arb_state_t        - arbiter FSM encoding (IDLE/ARB/XFER)
//   DEF_*              - default parameter values
//   id_width/cnt_width - width derivations for grant index and burst counter
package uart_tx_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARB  = 2'd1,
        XFER = 2'd2
    } arb_state_t;

    localparam int unsigned DEF_NUM_REQ   = 4;
    localparam int unsigned DEF_DATA_W    = 8;
    localparam int unsigned DEF_MAX_BURST = 16;

    // Width of a requester index (at least one bit).
    function automatic int unsigned id_width(input int unsigned n);
        return (n < 2) ? 32'd1 : 32'($clog2(n));
    endfunction

    // Width of a counter that must hold 0..m inclusive.
    function automatic int unsigned cnt_width(input int unsigned m);
        return 32'($clog2(m + 1));
    endfunction

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Requester / UART TX FIFO bundle for uart_tx_arbiter.
// Signals:
//   req_valid/req_data/req_last/req_ready - per-requester byte handshake
//   tx_data/tx_write/tx_full              - UART TX FIFO write port
//   grant_active/grant_id/burst_cnt       - grant status
// Modports:
//   slave  - the arbiter side
//   master - the requesters plus FIFO side (system top or testbench)
interface uart_tx_arbiter_if
    import uart_tx_arbiter_pkg::*;
#(
    parameter int unsigned NUM_REQ   = DEF_NUM_REQ,
    parameter int unsigned DATA_W    = DEF_DATA_W,
    parameter int unsigned MAX_BURST = DEF_MAX_BURST
) ();

    localparam int unsigned ID_W  = id_width(NUM_REQ);
    localparam int unsigned CNT_W = cnt_width(MAX_BURST);

    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ*DATA_W-1:0] req_data;
    logic [NUM_REQ-1:0]        req_last;
    logic [NUM_REQ-1:0]        req_ready;
    logic [DATA_W-1:0]         tx_data;
    logic                      tx_write;
    logic                      tx_full;
    logic                      grant_active;
    logic [ID_W-1:0]           grant_id;
    logic [CNT_W-1:0]          burst_cnt;

    modport slave (
        input  req_valid, req_data, req_last, tx_full,
        output req_ready, tx_data, tx_write, grant_active, grant_id, burst_cnt
    );

    modport master (
        output req_valid, req_data, req_last, tx_full,
        input  req_ready, tx_data, tx_write, grant_active, grant_id, burst_cnt
    );

endinterface

// File: rtl/uart_tx_arbiter_rr_pick.sv
// rr_pick: combinational round-robin priority selector.
// Ports:
//   i_req_valid - request vector
//   i_last_id   - index served last; the scan starts just after it
//   o_found     - at least one request is set
//   o_idx       - first set request at i_last_id+1, +2, ... modulo NUM_REQ
module rr_pick
    import uart_tx_arbiter_pkg::*;
#(
    parameter int unsigned NUM_REQ = DEF_NUM_REQ,
    parameter int unsigned ID_W    = id_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] i_req_valid,
    input  logic [ID_W-1:0]    i_last_id,
    output logic               o_found,
    output logic [ID_W-1:0]    o_idx
);

    logic [ID_W-1:0] w_cand;

    always_comb begin
        o_found = 1'b0;
        o_idx   = '0;
        w_cand  = '0;
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            w_cand = ID_W'((32'(i_last_id) + k) % NUM_REQ);
            if (!o_found && i_req_valid[w_cand]) begin
                o_found = 1'b1;
                o_idx   = w_cand;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: shares one UART TX FIFO write port between NUM_REQ
// byte-stream requesters with round-robin grants held for a whole packet,
// capped at MAX_BURST bytes per grant.
// Ports:
//   HCLK    - system clock
//   HRESETn - asynchronous active-low reset
//   bus     - uart_tx_arbiter_if.slave (requester handshakes, FIFO write
//             port, grant status)
module uart_tx_arbiter
    import uart_tx_arbiter_pkg::*;
#(
    parameter int unsigned NUM_REQ   = DEF_NUM_REQ,
    parameter int unsigned DATA_W    = DEF_DATA_W,
    parameter int unsigned MAX_BURST = DEF_MAX_BURST
) (
    input  logic             HCLK,
    input  logic             HRESETn,
    uart_tx_arbiter_if.slave bus
);

    localparam int unsigned       ID_W    = id_width(NUM_REQ);
    localparam int unsigned       CNT_W   = cnt_width(MAX_BURST);
    localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(MAX_BURST);

    arb_state_t          r_state;
    arb_state_t          w_next_state;
    logic [ID_W-1:0]     r_last_id;
    logic [ID_W-1:0]     r_grant_id;
    logic                r_grant_active;
    logic [CNT_W-1:0]    r_burst_cnt;
    logic [DATA_W-1:0]   r_tx_data;
    logic                r_tx_write;

    logic                w_found;
    logic [ID_W-1:0]     w_pick;
    logic                w_gnt_valid;
    logic                w_gnt_last;
    logic [DATA_W-1:0]   w_gnt_data;
    logic                w_ready_g;
    logic                w_xfer;
    logic                w_release;
    logic [CNT_W-1:0]    w_cnt_inc;
    logic [NUM_REQ-1:0]  w_ready;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_rr_pick (
        .i_req_valid (bus.req_valid),
        .i_last_id   (r_last_id),
        .o_found     (w_found),
        .o_idx       (w_pick)
    );

    assign w_gnt_valid = bus.req_valid[r_grant_id];
    assign w_gnt_last  = bus.req_last[r_grant_id];
    assign w_gnt_data  = bus.req_data[r_grant_id*DATA_W +: DATA_W];

    // Blocking ready during the write pulse gives one byte per two cycles,
    // so a full flag raised by the write we just issued is seen in time.
    assign w_ready_g = (r_state == XFER) && !bus.tx_full && !r_tx_write;
    assign w_xfer    = w_ready_g && w_gnt_valid;
    assign w_cnt_inc = (r_burst_cnt == CNT_MAX) ? r_burst_cnt : r_burst_cnt + 1'b1;
    assign w_release = w_xfer && (w_gnt_last || (w_cnt_inc == CNT_MAX));

    always_comb begin
        w_ready             = '0;
        w_ready[r_grant_id] = w_ready_g;
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (|bus.req_valid) w_next_state = ARB;
            ARB:     w_next_state = w_found ? XFER : IDLE;
            XFER:    if (w_release) w_next_state = ARB;
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_last_id      <= ID_W'(NUM_REQ - 1);
            r_grant_id     <= '0;
            r_grant_active <= 1'b0;
            r_burst_cnt    <= '0;
            r_tx_data      <= '0;
            r_tx_write     <= 1'b0;
        end else begin
            r_tx_write <= w_xfer;
            if (w_xfer) begin
                r_tx_data   <= w_gnt_data;
                r_burst_cnt <= w_cnt_inc;
            end
            if (w_release) begin
                r_last_id      <= r_grant_id;
                r_grant_active <= 1'b0;
            end
            if (r_state == ARB) begin
                r_burst_cnt <= '0;
                if (w_found) begin
                    r_grant_id     <= w_pick;
                    r_grant_active <= 1'b1;
                end
            end
        end
    end

    assign bus.req_ready    = w_ready;
    assign bus.tx_data      = r_tx_data;
    assign bus.tx_write     = r_tx_write;
    assign bus.grant_active = r_grant_active;
    assign bus.grant_id     = r_grant_id;
    assign bus.burst_cnt    = r_burst_cnt;

endmodule
